// File: rtl/sc_operand_sequencer.sv
// sc_operand_sequencer
//   Walks every (input row m, weight row o) pair of an M x O pass. For each
//   pair it reads both rows, holds them on op_input/op_weight while the
//   stochastic stream runs for STREAM_LEN cycles, then waits for the
//   downstream converter to acknowledge the result before moving on.
//   The weight index o is the inner loop and the row index m is the outer loop.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a full pass (accepted only when idle)
//   in_addr/in_rd_en    input-row read request; data returns one cycle later
//   in_rd_data          input row (BINARY_PRECISION*INPUT_FEATURES bits)
//   w_addr/w_rd_en      weight-row read request; data returns one cycle later
//   w_rd_data           weight row
//   op_input/op_weight  held operand vectors feeding the SNGs
//   op_valid            stream running with stable operands
//   stream_restart      first stream cycle of an element
//   conv_last           final stream cycle of an element
//   res_done            downstream captured the converted result
//   out_row/out_col     (m, o) of the element in flight
//   busy, done          pass in progress / one-cycle completion pulse
//   busy_cycles         busy-cycle counter (only with SC_SEQ_PERF_EN)
//
// Build option: define SC_SEQ_PERF_EN to add the busy_cycles counter output.

module sc_operand_sequencer #(
    parameter int BATCH_SIZE        = 4,
    parameter int INPUT_FEATURES    = 4,
    parameter int OUTPUT_FEATURES   = 4,
    parameter int BINARY_PRECISION  = 8,
    parameter int STOCHASTIC_CYCLES = 1,
    localparam int AW_M = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
    localparam int AW_O = (OUTPUT_FEATURES > 1) ? $clog2(OUTPUT_FEATURES) : 1,
    localparam int DW   = BINARY_PRECISION * INPUT_FEATURES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW_M-1:0] in_addr,
    output logic            in_rd_en,
    input  logic [DW-1:0]   in_rd_data,
    output logic [AW_O-1:0] w_addr,
    output logic            w_rd_en,
    input  logic [DW-1:0]   w_rd_data,
    output logic [DW-1:0]   op_input,
    output logic [DW-1:0]   op_weight,
    output logic            op_valid,
    output logic            stream_restart,
    output logic            conv_last,
    input  logic            res_done,
    output logic [AW_M-1:0] out_row,
    output logic [AW_O-1:0] out_col,
    output logic            busy,
    output logic            done
`ifdef SC_SEQ_PERF_EN
    ,
    output logic [31:0]     busy_cycles
`endif
);

    localparam int STREAM_LEN = STOCHASTIC_CYCLES * (1 << BINARY_PRECISION);
    // One spare bit so the counter can never wrap while reaching STREAM_LEN-1.
    localparam int CW = $clog2(STREAM_LEN) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        STREAM  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW_M-1:0] m_q, m_d;
    logic [AW_O-1:0] o_q, o_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   op_input_q, op_weight_q;

    logic cnt_last;
    logic last_m, last_o;

    assign cnt_last = (cnt_q == CW'(STREAM_LEN - 1));
    assign last_m   = (m_q == AW_M'(BATCH_SIZE - 1));
    assign last_o   = (o_q == AW_O'(OUTPUT_FEATURES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = STREAM;
            STREAM:  if (cnt_last) state_d = DRAIN;
            DRAIN:   if (res_done) state_d = (last_m && last_o) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Element indices and stream counter
    always_comb begin
        m_d   = m_q;
        o_d   = o_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d = '0;
                    o_d = '0;
                end
            end
            STREAM: cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
            DRAIN: begin
                if (res_done) begin
                    if (last_o) begin
                        o_d = '0;
                        m_d = last_m ? '0 : m_q + AW_M'(1);
                    end else begin
                        o_d = o_q + AW_O'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= '0;
            o_q   <= '0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            o_q   <= o_d;
            cnt_q <= cnt_d;
        end
    end

    // Operand hold registers: loaded only at the end of CAPTURE, when the
    // read data requested in FETCH is on the memory outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_input_q  <= '0;
            op_weight_q <= '0;
        end else if (state_q == CAPTURE) begin
            op_input_q  <= in_rd_data;
            op_weight_q <= w_rd_data;
        end
    end

    // Output logic
    always_comb begin
        in_rd_en       = (state_q == FETCH);
        w_rd_en        = (state_q == FETCH);
        in_addr        = (state_q == FETCH) ? m_q : '0;
        w_addr         = (state_q == FETCH) ? o_q : '0;
        op_valid       = (state_q == STREAM);
        stream_restart = (state_q == STREAM) && (cnt_q == '0);
        conv_last      = (state_q == STREAM) && cnt_last;
        busy           = (state_q == FETCH) || (state_q == CAPTURE) ||
                         (state_q == STREAM) || (state_q == DRAIN);
        done           = (state_q == DONE);
        out_row        = busy ? m_q : '0;
        out_col        = busy ? o_q : '0;
        op_input       = op_input_q;
        op_weight      = op_weight_q;
    end

`ifdef SC_SEQ_PERF_EN
    logic [31:0] busy_cycles_q;

    always_ff @(posedge clk) begin
        if (rst)
            busy_cycles_q <= '0;
        else if (state_q == IDLE && start)
            busy_cycles_q <= '0;
        else if (busy && busy_cycles_q != '1)
            busy_cycles_q <= busy_cycles_q + 32'd1;
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: doc/sc_operand_sequencer.md
SC_OPERAND_SEQUENCER -- requirements
Module: sc_operand_sequencer

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 4: number of input rows (M).
REQ-002 SHALL have parameter INPUT_FEATURES, default 4: elements per operand vector (N).
REQ-003 SHALL have parameter OUTPUT_FEATURES, default 4: number of weight rows (O).
REQ-004 SHALL have parameter BINARY_PRECISION, default 8: bits per element (P).
REQ-005 SHALL have parameter STOCHASTIC_CYCLES, default 1: stream length multiplier; STREAM_LEN = STOCHASTIC_CYCLES * 2^P.
REQ-006 SHALL have ports (AW_M = max(1,clog2(M)), AW_O = max(1,clog2(O))):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin full M x O pass
- in_addr  out  AW_M  input-row read address
- in_rd_en  out  1  input-row read strobe
- in_rd_data  in  P*N  input row, valid one cycle after in_rd_en
- w_addr  out  AW_O  weight-row read address
- w_rd_en  out  1  weight-row read strobe
- w_rd_data  in  P*N  weight row, valid one cycle after w_rd_en
- op_input  out  P*N  held input vector to SNGs
- op_weight  out  P*N  held weight vector to SNGs
- op_valid  out  1  operands stable, stream running
- stream_restart  out  1  pulse, first stream cycle
- conv_last  out  1  pulse, final stream cycle
- res_done  in  1  downstream has captured the converted result
- out_row  out  AW_M  row index of the current result
- out_col  out  AW_O  column index of the current result
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse, pass complete

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, CAPTURE, STREAM, DRAIN, DONE.
REQ-008 IDLE: start=1 -> FETCH next cycle, m=0, o=0; otherwise hold.
REQ-009 FETCH (1 cycle): in_rd_en=w_rd_en=1, in_addr=m, w_addr=o -> CAPTURE.
REQ-010 CAPTURE (1 cycle): register in_rd_data/w_rd_data into op_input/op_weight -> STREAM.
REQ-011 STREAM: op_valid=1 for exactly STREAM_LEN cycles; stream_restart=1 on the first cycle, conv_last=1 on the last, then -> DRAIN.
REQ-012 When STREAM_LEN=1, stream_restart and conv_last SHALL be asserted in the same cycle.
REQ-013 op_input/op_weight SHALL stay constant from CAPTURE exit until the next CAPTURE.
REQ-014 DRAIN: wait for res_done=1; on that cycle, advance o (inner loop) then m (outer loop) and go to FETCH, or go to DONE when m=M-1 and o=O-1.
REQ-015 out_row/out_col SHALL equal the current m/o from FETCH through DRAIN inclusive.
REQ-016 DONE (1 cycle): done=1 -> IDLE.
REQ-017 busy SHALL be 1 in FETCH, CAPTURE, STREAM and DRAIN, and 0 in IDLE and DONE.
REQ-018 start outside IDLE SHALL be ignored; res_done outside DRAIN SHALL be ignored.
REQ-019 Stream counter width SHALL be clog2(STREAM_LEN)+1; wrap-around SHALL NOT occur.

Reset
REQ-020 rst SHALL force IDLE, m=o=0, counter=0, and all outputs to 0 (op_input/op_weight included) on the next edge, including mid-pass.
REQ-021 rst SHALL take priority over start and res_done in the same cycle.

Configuration
REQ-022 With SC_SEQ_PERF_EN defined, the block SHALL add output busy_cycles [31:0]: it increments each cycle busy=1, saturates at 2^32-1, is cleared by rst and by start accepted in IDLE, and holds otherwise.
REQ-023 Without SC_SEQ_PERF_EN, busy_cycles and its logic SHALL be absent.

Verification
REQ-024 Defaults, start pulse, res_done on the first DRAIN cycle each time -> 16 results in (o,m) order (0,0),(1,0)..(3,3); done 4144 cycles after the start-accept edge; busy_cycles=4144.
REQ-025 Memory row m = {N{8'(m+1)}}, weight row o = {N{8'(o+0x10)}} -> op_input/op_weight match and stay stable for all 256 op_valid cycles of each element.
REQ-026 res_done delayed 10 cycles in DRAIN for element (1,2) -> FSM holds, out_row=1, out_col=2; FETCH for (1,3) follows the res_done cycle.
REQ-027 rst asserted at stream cycle 100 of element (2,1) -> all outputs 0 next cycle; a fresh start begins at (0,0).
REQ-028 STOCHASTIC_CYCLES=1, P=1 (STREAM_LEN=2) -> stream_restart and conv_last on consecutive cycles; start pulsed during STREAM -> ignored.
REQ-029 M=1, O=1 -> exactly one FETCH; done follows the single res_done; AW_M=AW_O=1 and addresses stay 0.
